// File: rtl/id_scoreboard_pkg.sv
// Shared types and sizing for the decode-stage register hazard scoreboard.
package id_scoreboard_pkg;

  localparam int unsigned REG_AW    = 3;
  localparam int unsigned NREG      = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MAX_PEND  = 3;
  localparam int unsigned PEND_W    = $clog2(MAX_PEND + 1);
  localparam int unsigned STALL_MAX = 64;
  localparam int unsigned STALL_W   = $clog2(STALL_MAX + 1);
  localparam int unsigned NSRC      = 3;

  typedef logic [REG_AW-1:0]  reg_addr_t;
  typedef logic [PEND_W-1:0]  pend_cnt_t;
  typedef logic [STALL_W-1:0] stall_cnt_t;
  typedef logic [NREG-1:0]    reg_vec_t;

  // One-hot register select for a 3-bit register address.
  function automatic reg_vec_t reg_onehot(input reg_addr_t addr);
    return reg_vec_t'(1) << addr;
  endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// Decode/writeback side-band bundle between the decoder and the scoreboard.
interface id_scoreboard_if;
  import id_scoreboard_pkg::*;

  logic            issue_valid;
  reg_addr_t       src1_addr;
  reg_addr_t       src2_addr;
  reg_addr_t       src3_addr;
  logic [NSRC-1:0] src_use;
  reg_addr_t       dst_addr;
  logic            dst_valid;
  logic            wb_valid;
  reg_addr_t       wb_addr;
  logic            flush;
  logic            stall;
  logic            issue_fire;
  reg_vec_t        busy_vec;
  logic            hang;
  logic            wb_err;

  // Decoder / pipeline control side.
  modport master (
    output issue_valid, src1_addr, src2_addr, src3_addr, src_use,
    output dst_addr, dst_valid, wb_valid, wb_addr, flush,
    input  stall, issue_fire, busy_vec, hang, wb_err
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid, src1_addr, src2_addr, src3_addr, src_use,
    input  dst_addr, dst_valid, wb_valid, wb_addr, flush,
    output stall, issue_fire, busy_vec, hang, wb_err
  );

endinterface

// File: rtl/id_pend_counter.sv
// Per-register count of in-flight writes: up on issue, down on writeback.
module id_pend_counter
  import id_scoreboard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      inc,
  input  logic      dec,
  output pend_cnt_t cnt,
  output logic      nonzero
);

  logic dec_ok;
  logic up;
  logic down;

  assign nonzero = (cnt != '0);
  // A writeback against an empty counter is ignored here; the top flags it.
  assign dec_ok  = dec && nonzero;
  // Simultaneous inc and dec cancel; the top never issues into a full counter.
  assign up      = inc && !dec_ok && (cnt != PEND_W'(MAX_PEND));
  assign down    = dec_ok && !inc;

  // Counter state: flush discards every pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (up) begin
      cnt <= cnt + PEND_W'(1);
    end else if (down) begin
      cnt <= cnt - PEND_W'(1);
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// Register hazard scoreboard and issue controller for the decode stage.
module id_scoreboard
  import id_scoreboard_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  id_scoreboard_if.slave bus
);

  pend_cnt_t  pend_cnt [NREG];
  reg_vec_t   busy;
  reg_vec_t   inc_vec;
  reg_vec_t   dec_vec;
  logic       raw;
  logic       waw_full;
  logic       hazard;
  logic       stall_c;
  logic       fire_c;
  logic       wb_spurious;
  stall_cnt_t stall_cnt;
  logic       hang_q;
  logic       wb_err_q;

  // Issued destinations count up; writebacks count down unless flushing.
  assign inc_vec = (fire_c && bus.dst_valid) ? reg_onehot(bus.dst_addr) : '0;
  assign dec_vec = (bus.wb_valid && !bus.flush) ? reg_onehot(bus.wb_addr) : '0;

  for (genvar r = 0; r < NREG; r++) begin : g_pend
    id_pend_counter u_pend (
      .clk     (clk),
      .rst     (rst),
      .flush   (bus.flush),
      .inc     (inc_vec[r]),
      .dec     (dec_vec[r]),
      .cnt     (pend_cnt[r]),
      .nonzero (busy[r])
    );
  end

  // Read-after-write and write-saturation hazards against current counts.
  always_comb begin
    raw      = 1'b0;
    waw_full = 1'b0;
    if (bus.src_use[0] && busy[bus.src1_addr]) raw = 1'b1;
    if (bus.src_use[1] && busy[bus.src2_addr]) raw = 1'b1;
    if (bus.src_use[2] && busy[bus.src3_addr]) raw = 1'b1;
    if (bus.dst_valid && (pend_cnt[bus.dst_addr] == PEND_W'(MAX_PEND))) waw_full = 1'b1;
  end

  // Zero-latency issue decision; both held low while reset is asserted.
  assign hazard      = raw || waw_full;
  assign stall_c     = !rst && bus.issue_valid && !bus.flush && hazard;
  assign fire_c      = !rst && bus.issue_valid && !bus.flush && !hazard;
  assign wb_spurious = bus.wb_valid && !bus.flush && !busy[bus.wb_addr];

  // Watchdog: count consecutive stall cycles and latch hang at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      hang_q    <= 1'b0;
    end else begin
      if (!stall_c) begin
        stall_cnt <= '0;
      end else if (stall_cnt != STALL_W'(STALL_MAX)) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
      if (stall_c && (stall_cnt == STALL_W'(STALL_MAX - 1))) begin
        hang_q <= 1'b1;
      end
    end
  end

  // Sticky error for a writeback that has no matching pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_err_q <= 1'b0;
    end else if (wb_spurious) begin
      wb_err_q <= 1'b1;
    end
  end

  assign bus.stall      = stall_c;
  assign bus.issue_fire = fire_c;
  assign bus.busy_vec   = busy;
  assign bus.hang       = hang_q;
  assign bus.wb_err     = wb_err_q;

endmodule
